// File: rtl/font_writer8x12.sv
// Glyph-RAM write engine for the 8x12 font: gathers a 24-bit scan row
// from three byte writes, then emits it as eight single-alpha RAM writes.
module font_writer8x12 (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wr,
    input  logic [1:0]  i_addr,
    input  logic [7:0]  i_data,
    output logic        o_ready,
    output logic        o_err,
    output logic        o_we,
    output logic [14:0] o_waddr,
    output logic [2:0]  o_wdata
);

    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [1:0] A_CHAR = 2'd0;
    localparam logic [1:0] A_ROW  = 2'd1;
    localparam logic [1:0] A_DATA = 2'd2;
    localparam logic [1:0] A_CTRL = 2'd3;

    state_t      state_q, state_d;
    logic [7:0]  char_q, char_d;
    logic [3:0]  row_q, row_d;
    logic [1:0]  bidx_q, bidx_d;
    logic [23:0] word_q, word_d;
    logic [2:0]  col_q, col_d;
    logic        err_q, err_d;
    logic [14:0] waddr_q, waddr_d;
    logic [2:0]  wdata_q, wdata_d;

    logic        accept;
    logic        row_done;
    logic [2:0]  col_nx;
    logic [4:0]  col_base;

    assign accept   = i_wr && (state_q == IDLE);
    assign row_done = accept && (i_addr == A_DATA) && (bidx_q == 2'd2);
    assign col_nx   = col_q + 3'd1;
    assign col_base = {2'b00, col_nx} * 5'd3;

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (row_done) state_d = EMIT;
            EMIT: if (col_q == 3'd7) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state_q == IDLE);
        o_we    = (state_q == EMIT);
        o_err   = err_q;
        o_waddr = waddr_q;
        o_wdata = wdata_q;
    end

    always_comb begin
        char_d  = char_q;
        row_d   = row_q;
        bidx_d  = bidx_q;
        word_d  = word_q;
        col_d   = col_q;
        err_d   = err_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (accept) begin
            unique case (i_addr)
                A_CHAR: begin
                    char_d = i_data;
                    bidx_d = 2'd0;
                end
                A_ROW: begin
                    if (i_data[3:0] <= 4'd11) begin
                        row_d  = i_data[3:0];
                        bidx_d = 2'd0;
                    end
                end
                A_DATA: begin
                    word_d[8*bidx_q +: 8] = i_data;
                    if (bidx_q == 2'd2) begin
                        bidx_d  = 2'd0;
                        col_d   = 3'd0;
                        waddr_d = {row_q, char_q, 3'd0};
                        wdata_d = word_d[2:0];
                    end else begin
                        bidx_d = bidx_q + 2'd1;
                    end
                end
                A_CTRL: begin
                    if (i_data[0]) err_d = 1'b0;
                    if (i_data[1]) bidx_d = 2'd0;
                end
                default: ;
            endcase
        end
        if (state_q == EMIT) begin
            col_d = col_nx;
            if (col_q == 3'd7) begin
                // Auto-advance: rows 0..11 within a char, then next char
                if (row_q == 4'd11) begin
                    row_d  = 4'd0;
                    char_d = char_q + 8'd1;
                end else begin
                    row_d = row_q + 4'd1;
                end
            end else begin
                waddr_d = {row_q, char_q, col_nx};
                wdata_d = word_q[col_base +: 3];
            end
        end
        // Set wins over a same-cycle CTRL clear
        if ((i_wr && state_q != IDLE) ||
            (accept && i_addr == A_ROW && i_data[3:0] > 4'd11))
            err_d = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            char_q  <= '0;
            row_q   <= '0;
            bidx_q  <= '0;
            word_q  <= '0;
            col_q   <= '0;
            err_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            char_q  <= char_d;
            row_q   <= row_d;
            bidx_q  <= bidx_d;
            word_q  <= word_d;
            col_q   <= col_d;
            err_q   <= err_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_font_writer8x12.sv
// Bench for font_writer8x12: a row-level model predicts every RAM write,
// plus literal address/data checks on selected rows.
module tb_font_writer8x12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [7:0]  data = 8'd0;
    logic        ready, err, we;
    logic [14:0] waddr;
    logic [2:0]  wdata;

    int total = 0;
    int bad = 0;

    font_writer8x12 dut (
        .i_clk(clk), .i_rst(rst), .i_wr(wr), .i_addr(addr), .i_data(data),
        .o_ready(ready), .o_err(err), .o_we(we),
        .o_waddr(waddr), .o_wdata(wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: whole rows, expected write list, busy time
    int m_busy, m_char, m_row, m_nb, m_err;
    int m_bytes [3];
    int q_addr [$];
    int q_data [$];
    int m_laddr, m_ldata;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_char = 0; m_row = 0; m_nb = 0; m_err = 0;
            q_addr.delete(); q_data.delete();
            m_laddr = 0; m_ldata = 0;
        end else begin
            int ne, clr, w;
            ne = 0; clr = 0;
            if (m_busy > 0) begin
                if (wr) ne = 1;
                m_busy--;
            end else if (wr) begin
                case (addr)
                    2'd0: begin m_char = data; m_nb = 0; end
                    2'd1: begin
                        if ((data % 16) <= 11) begin
                            m_row = data % 16; m_nb = 0;
                        end else ne = 1;
                    end
                    2'd2: begin
                        m_bytes[m_nb] = data;
                        m_nb++;
                        if (m_nb == 3) begin
                            m_nb = 0;
                            w = m_bytes[0] + 256 * m_bytes[1] + 65536 * m_bytes[2];
                            for (int c = 0; c < 8; c++) begin
                                q_addr.push_back(m_row * 2048 + m_char * 8 + c);
                                q_data.push_back((w >> (3 * c)) % 8);
                            end
                            m_busy = 8;
                            if (m_row == 11) begin
                                m_row = 0; m_char = (m_char + 1) % 256;
                            end else m_row++;
                        end
                    end
                    default: begin
                        if (data[0]) clr = 1;
                        if (data[1]) m_nb = 0;
                    end
                endcase
            end
            if (clr) m_err = 0;
            if (ne) m_err = 1;
        end
    end

    always @(negedge clk) begin
        chk("ready", int'(ready), int'(m_busy == 0));
        chk("err", int'(err), m_err);
        chk("we", int'(we), int'(m_busy > 0));
        if (we) begin
            if (q_addr.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                m_laddr = q_addr.pop_front();
                m_ldata = q_data.pop_front();
                chk("waddr", int'(waddr), m_laddr);
                chk("wdata", int'(wdata), m_ldata);
            end
        end else begin
            chk("hold_waddr", int'(waddr), m_laddr);
            chk("hold_wdata", int'(wdata), m_ldata);
        end
    end

    task automatic wreg(input logic [1:0] a, input logic [7:0] d);
        @(posedge clk); #2;
        wr = 1'b1; addr = a; data = d;
        @(posedge clk); #2;
        wr = 1'b0;
    endtask

    task automatic wait_col(input int col);
        int n;
        n = 0;
        @(negedge clk);
        while (!(we && int'(waddr[2:0]) == col) && n < 40) begin
            @(negedge clk); n++;
        end
        if (n >= 40) chk("timeout_col", 0, 1);
    endtask

    // Literal row check: data equals column index 0..7 at base+c
    task automatic lit_row(input string nm, input int base);
        wait_col(0);
        for (int c = 0; c < 8; c++) begin
            chk({nm, "_we"}, int'(we), 1);
            chk({nm, "_addr"}, int'(waddr), base + c);
            chk({nm, "_data"}, int'(wdata), c);
            @(negedge clk);
        end
        chk({nm, "_we_off"}, int'(we), 0);
        chk({nm, "_rdy"}, int'(ready), 1);
    endtask

    task automatic row_bytes(input logic [7:0] b0, b1, b2);
        wreg(2'd2, b0); wreg(2'd2, b1); wreg(2'd2, b2);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", int'(ready), 1);
        chk("rst_we", int'(we), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_waddr", int'(waddr), 0);
        chk("rst_wdata", int'(wdata), 0);

        wreg(2'd0, 8'h41); wreg(2'd1, 8'h03);
        row_bytes(8'h88, 8'hC6, 8'hFA);
        lit_row("r3c41", 3 * 2048 + 8'h41 * 8);
        row_bytes(8'h88, 8'hC6, 8'hFA);
        lit_row("r4c41", 4 * 2048 + 8'h41 * 8);

        wreg(2'd0, 8'hFF); wreg(2'd1, 8'hFB);
        row_bytes(8'h88, 8'hC6, 8'hFA);
        lit_row("top", 24568);
        row_bytes(8'h88, 8'hC6, 8'hFA);
        lit_row("wrap", 0);

        wreg(2'd1, 8'h0C);
        @(negedge clk);
        chk("row12_err", int'(err), 1);
        wreg(2'd3, 8'h01);
        @(negedge clk);
        chk("clr_err", int'(err), 0);
        row_bytes(8'h12, 8'h34, 8'h56);
        wait_col(7);
        @(negedge clk);

        row_bytes(8'hA5, 8'h5A, 8'hFF);
        wait_col(4);
        wr = 1'b1; addr = 2'd2; data = 8'h55;
        @(posedge clk); #2 wr = 1'b0;
        wait_col(7);
        wr = 1'b1; addr = 2'd2; data = 8'h66;
        @(posedge clk); #2 wr = 1'b0;
        @(negedge clk);
        chk("drop_err", int'(err), 1);
        wreg(2'd3, 8'h01);

        wreg(2'd2, 8'h11); wreg(2'd2, 8'h22);
        wreg(2'd3, 8'h02);
        row_bytes(8'h77, 8'h31, 8'h9C);
        wait_col(7);
        @(negedge clk);

        // Clear and a fresh error in the same cycle: error stays set
        wreg(2'd0, 8'h10);
        row_bytes(8'hFF, 8'h00, 8'hF0);
        wait_col(7);
        wr = 1'b1; addr = 2'd3; data = 8'h01;
        @(posedge clk); #2 wr = 1'b0;
        @(negedge clk);
        chk("set_wins", int'(err), 1);

        row_bytes(8'h0F, 8'hF0, 8'h3C);
        wait_col(3);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_we", int'(we), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst2_ready", int'(ready), 1);
        chk("rst2_err", int'(err), 0);
        chk("rst2_waddr", int'(waddr), 0);
        chk("rst2_wdata", int'(wdata), 0);
        row_bytes(8'h88, 8'hC6, 8'hFA);
        lit_row("after_rst", 0);

        repeat (3) @(negedge clk);
        chk("queue_empty", q_addr.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
